// File: rtl/mst_chk_pkg.sv
// Shared types, constants and the pattern step for the channel-0 loopback checker.
package mst_chk_pkg;

    localparam int unsigned DAT_W = 16;

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } chk_state_e;

    // Next word of the incrementing test pattern, wrapping FFFF -> 0000.
    function automatic logic [DAT_W-1:0] nxt_pat(input logic [DAT_W-1:0] d);
        return d + DAT_W'(1);
    endfunction

endpackage

// File: rtl/mst_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module mst_sat_cnt #(
    parameter int unsigned W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count up to MAX and hold there until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mst_data_chk.sv
// Channel-0 incrementing-pattern checker: sticky error, counters, first-mismatch capture, lock.
module mst_data_chk
    import mst_chk_pkg::*;
#(
    parameter int unsigned LOCK_LEN      = 16,
    parameter bit          SEED_ON_FIRST = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ch0_vld,
    input  logic [DAT_W-1:0] ch0_dat,
    input  logic             chk_clr,
    output logic             chk_err,
    output logic             chk_lock,
    output logic [15:0]      err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [DAT_W-1:0] err_exp,
    output logic [DAT_W-1:0] err_got
);

    localparam int unsigned     RUN_W   = 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_LEN);

    chk_state_e       state_q, state_d;
    logic [DAT_W-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic             lock_q, lock_d;
    logic [DAT_W-1:0] err_exp_q, err_exp_d;
    logic [DAT_W-1:0] err_got_q, err_got_d;
    logic [RUN_W-1:0] run_cnt;

    logic acc_c;
    logic cmp_c;
    logic hit_c;
    logic miss_c;

    // A word is accepted unless a clear arrives in the same cycle; the seed word is only compared when seeding is off.
    assign acc_c  = ch0_vld && !chk_clr;
    assign cmp_c  = acc_c && ((state_q == CHECK) || !SEED_ON_FIRST);
    assign hit_c  = cmp_c && (ch0_dat == exp_q);
    assign miss_c = cmp_c && (ch0_dat != exp_q);

    // Next-state logic: FSM, expected value (resyncs on every accepted word), sticky flags, capture.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        err_d     = err_q;
        lock_d    = lock_q;
        err_exp_d = err_exp_q;
        err_got_d = err_got_q;

        if (chk_clr) begin
            state_d   = SEED;
            exp_d     = '0;
            err_d     = 1'b0;
            lock_d    = 1'b0;
            err_exp_d = '0;
            err_got_d = '0;
        end else if (acc_c) begin
            state_d = CHECK;
            exp_d   = nxt_pat(ch0_dat);
            if (hit_c && (run_cnt >= (RUN_MAX - RUN_W'(1)))) begin
                lock_d = 1'b1;
            end
            if (miss_c) begin
                err_d  = 1'b1;
                lock_d = 1'b0;
                if (!err_q) begin
                    err_exp_d = exp_q;
                    err_got_d = ch0_dat;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEED;
            exp_q     <= '0;
            err_q     <= 1'b0;
            lock_q    <= 1'b0;
            err_exp_q <= '0;
            err_got_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            lock_q    <= lock_d;
            err_exp_q <= err_exp_d;
            err_got_q <= err_got_d;
        end
    end

    // Mismatch count.
    mst_sat_cnt #(
        .W   (16),
        .MAX ('1)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (chk_clr),
        .inc_i (miss_c),
        .cnt_o (err_cnt)
    );

    // Accepted-word count, including the seed word.
    mst_sat_cnt #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (chk_clr),
        .inc_i (acc_c),
        .cnt_o (word_cnt)
    );

    // Consecutive-match run length, restarted by a mismatch.
    mst_sat_cnt #(
        .W   (RUN_W),
        .MAX (RUN_MAX)
    ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (chk_clr || miss_c),
        .inc_i (hit_c),
        .cnt_o (run_cnt)
    );

    assign chk_err  = err_q;
    assign chk_lock = lock_q;
    assign err_exp  = err_exp_q;
    assign err_got  = err_got_q;

endmodule
